axi_lite_regfile: RTL and testbench



---
 rtl/axi_lite_regfile_if.sv | 33 +++
 rtl/axi_lite_regfile.sv | 181 ++++++++++++++++++
 tb/tb_axi_lite_regfile.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/axi_lite_regfile_if.sv
// AXI4-Lite bus bundle between the bus block (master) and a register target (slave).
interface axi_lite_regfile_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0]   awaddr;
  logic                    awvalid;
  logic                    awready;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wvalid;
  logic                    wready;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;
  logic [ADDR_WIDTH-1:0]   araddr;
  logic                    arvalid;
  logic                    arready;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rvalid;
  logic                    rready;

  modport master (
    output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );

  modport slave (
    input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
    output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
  );
endinterface

// File: rtl/axi_lite_regfile.sv
// AXI4-Lite register bank target: NUM_REGS word registers, byte-strobe writes, SLVERR on decode miss.
// Optional AXIL_REGFILE_ID_EN: register 0 becomes a read-only ID constant (ID_VALUE).
module axi_lite_regfile #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    ADDR_WIDTH = 8,
  parameter int                    NUM_REGS   = 8,
  parameter logic [DATA_WIDTH-1:0] ID_VALUE   = DATA_WIDTH'(32'hA5A5_0001)
) (
  input  logic                     s0_axi_aclk,
  input  logic                     s0_axi_aresetn,
  axi_lite_regfile_if.slave        s0_axi
);
  localparam int         IDX_W       = ADDR_WIDTH - 2;
  localparam int         STRB_W      = DATA_WIDTH / 8;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
`ifdef AXIL_REGFILE_ID_EN
  localparam bit ID_EN = 1'b1;
`else
  localparam bit ID_EN = 1'b0;
`endif

  typedef enum logic [1:0] {W_IDLE, W_ADDR, W_DATA, W_RESP} wstate_e;
  typedef enum logic       {R_IDLE, R_RESP} rstate_e;

  wstate_e                 wstate_q;
  rstate_e                 rstate_q;
  logic                    awready_q, wready_q, bvalid_q;
  logic [1:0]              bresp_q;
  logic                    arready_q, rvalid_q;
  logic [1:0]              rresp_q;
  logic [DATA_WIDTH-1:0]   rdata_q;
  logic [IDX_W-1:0]        aw_idx_q;
  logic [DATA_WIDTH-1:0]   w_data_q;
  logic [STRB_W-1:0]       w_strb_q;

  logic                    aw_hs, w_hs, ar_hs, commit, wr_err, rd_err;
  logic [IDX_W-1:0]        wr_idx, rd_idx;
  logic [DATA_WIDTH-1:0]   wr_data, rd_val;
  logic [STRB_W-1:0]       wr_strb;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0] regs;

  assign aw_hs = s0_axi.awvalid & awready_q;
  assign w_hs  = s0_axi.wvalid  & wready_q;
  assign ar_hs = s0_axi.arvalid & arready_q;

  // The later half of a write commits straight from the bus, so bvalid follows it by one cycle.
  assign wr_idx  = aw_hs ? s0_axi.awaddr[ADDR_WIDTH-1:2] : aw_idx_q;
  assign wr_data = w_hs  ? s0_axi.wdata : w_data_q;
  assign wr_strb = w_hs  ? s0_axi.wstrb : w_strb_q;
  assign commit  = ((wstate_q == W_IDLE) && aw_hs && w_hs) ||
                   ((wstate_q == W_ADDR) && w_hs) ||
                   ((wstate_q == W_DATA) && aw_hs);
  assign wr_err  = (32'(wr_idx) >= NUM_REGS) || (ID_EN && (wr_idx == '0));

  assign rd_idx  = s0_axi.araddr[ADDR_WIDTH-1:2];
  assign rd_err  = (32'(rd_idx) >= NUM_REGS);

  for (genvar r = 0; r < NUM_REGS; r++) begin : g_reg
    if (ID_EN && (r == 0)) begin : g_id
      assign regs[r] = ID_VALUE;
    end else begin : g_rw
      logic [DATA_WIDTH-1:0] q;
      logic                  we;
      assign we = commit && !wr_err && (32'(wr_idx) == r);
      always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
        if (!s0_axi_aresetn) begin
          q <= '0;
        end else if (we) begin
          for (int b = 0; b < STRB_W; b++)
            if (wr_strb[b]) q[8*b +: 8] <= wr_data[8*b +: 8];
        end
      end
      assign regs[r] = q;
    end
  end

  // Out-of-range indices match nothing, so the mux already yields zero for them.
  always_comb begin
    rd_val = '0;
    for (int r = 0; r < NUM_REGS; r++)
      if (32'(rd_idx) == r) rd_val = regs[r];
  end

  // Holding state: W_ADDR/W_RESP imply the address is held, W_DATA/W_RESP the data.
  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      aw_idx_q  <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      if (aw_hs) aw_idx_q <= s0_axi.awaddr[ADDR_WIDTH-1:2];
      if (w_hs) begin
        w_data_q <= s0_axi.wdata;
        w_strb_q <= s0_axi.wstrb;
      end
      if (commit) begin
        wstate_q  <= W_RESP;
        bvalid_q  <= 1'b1;
        bresp_q   <= wr_err ? RESP_SLVERR : RESP_OKAY;
        awready_q <= 1'b0;
        wready_q  <= 1'b0;
      end else begin
        case (wstate_q)
          W_IDLE: begin
            if (aw_hs) begin
              wstate_q  <= W_ADDR;
              awready_q <= 1'b0;
              wready_q  <= 1'b1;
            end else if (w_hs) begin
              wstate_q  <= W_DATA;
              awready_q <= 1'b1;
              wready_q  <= 1'b0;
            end else begin
              awready_q <= 1'b1;
              wready_q  <= 1'b1;
            end
          end
          W_RESP: begin
            if (s0_axi.bready) begin
              wstate_q  <= W_IDLE;
              bvalid_q  <= 1'b0;
              awready_q <= 1'b1;
              wready_q  <= 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge s0_axi_aclk or negedge s0_axi_aresetn) begin
    if (!s0_axi_aresetn) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
    end else begin
      case (rstate_q)
        R_IDLE: begin
          if (ar_hs) begin
            rstate_q  <= R_RESP;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b1;
            rdata_q   <= rd_val;
            rresp_q   <= rd_err ? RESP_SLVERR : RESP_OKAY;
          end else begin
            arready_q <= 1'b1;
          end
        end
        R_RESP: begin
          if (s0_axi.rready) begin
            rstate_q  <= R_IDLE;
            rvalid_q  <= 1'b0;
            arready_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign s0_axi.awready = awready_q;
  assign s0_axi.wready  = wready_q;
  assign s0_axi.bvalid  = bvalid_q;
  assign s0_axi.bresp   = bresp_q;
  assign s0_axi.arready = arready_q;
  assign s0_axi.rvalid  = rvalid_q;
  assign s0_axi.rresp   = rresp_q;
  assign s0_axi.rdata   = rdata_q;

  logic unused_ok;
  assign unused_ok = ^{s0_axi.awaddr[1:0], s0_axi.araddr[1:0], ID_VALUE};
endmodule

// File: tb/tb_axi_lite_regfile.sv
// Directed bench for axi_lite_regfile: handshakes, strobes, decode errors, backpressure, ordering, reset.
module tb_axi_lite_regfile;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam logic [1:0] OK  = 2'b00;
  localparam logic [1:0] SLV = 2'b10;

  logic gclk = 1'b0;
  logic grst_n = 1'b0;
  always #5 gclk = ~gclk;

  axi_lite_regfile_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s0_axi ();

  axi_lite_regfile #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_REGS(8), .ID_VALUE(32'hA5A5_0001)
  ) dut (
    .s0_axi_aclk   (gclk),
    .s0_axi_aresetn(grst_n),
    .s0_axi        (s0_axi)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Entered and left at posedge+1; W leads AW by w_lead cycles; bready held low b_hold cycles.
  task automatic wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                    input int w_lead, input int b_hold, input logic [1:0] exp_resp);
    bit aw_done = 0, w_done = 0, aw_go, w_go;
    int n = 0;
    s0_axi.awaddr = a; s0_axi.wdata = d; s0_axi.wstrb = s;
    s0_axi.wvalid = 1'b1; s0_axi.awvalid = 1'b0;
    while (!(aw_done && w_done) && n < 40) begin
      if (n >= w_lead && !aw_done) s0_axi.awvalid = 1'b1;
      @(negedge gclk);
      aw_go = s0_axi.awvalid && s0_axi.awready;
      w_go  = s0_axi.wvalid && s0_axi.wready;
      @(posedge gclk); #1;
      if (aw_go) begin aw_done = 1; s0_axi.awvalid = 1'b0; end
      if (w_go)  begin w_done = 1;  s0_axi.wvalid  = 1'b0; end
      n++;
    end
    s0_axi.awvalid = 1'b0; s0_axi.wvalid = 1'b0;
    check("wr_hs", {aw_done, w_done}, 2'b11);
    check("b_lat", s0_axi.bvalid, 1'b1);
    check("bresp", s0_axi.bresp, exp_resp);
    for (int i = 0; i < b_hold; i++) begin
      @(posedge gclk); #1;
      check("bhold_vld", s0_axi.bvalid, 1'b1);
      check("bhold_resp", s0_axi.bresp, exp_resp);
      check("bhold_rdy", {s0_axi.awready, s0_axi.wready}, 2'b00);
    end
    s0_axi.bready = 1'b1;
    @(posedge gclk); #1;
    s0_axi.bready = 1'b0;
    check("b_done", {s0_axi.bvalid, s0_axi.awready, s0_axi.wready}, 3'b011);
  endtask

  task automatic rd(input logic [7:0] a, input int r_hold,
                    input logic [31:0] exp_data, input logic [1:0] exp_resp);
    bit go = 0;
    int n = 0;
    s0_axi.araddr = a; s0_axi.arvalid = 1'b1;
    while (!go && n < 40) begin
      @(negedge gclk); go = s0_axi.arready;
      @(posedge gclk); #1;
      n++;
    end
    s0_axi.arvalid = 1'b0;
    check("ar_hs", go, 1'b1);
    check("r_lat", s0_axi.rvalid, 1'b1);
    check("rdata", s0_axi.rdata, exp_data);
    check("rresp", s0_axi.rresp, exp_resp);
    for (int i = 0; i < r_hold; i++) begin
      @(posedge gclk); #1;
      check("rhold_vld", s0_axi.rvalid, 1'b1);
      check("rhold_data", s0_axi.rdata, exp_data);
      check("rhold_rdy", s0_axi.arready, 1'b0);
    end
    s0_axi.rready = 1'b1;
    @(posedge gclk); #1;
    s0_axi.rready = 1'b0;
    check("r_done", {s0_axi.rvalid, s0_axi.arready}, 2'b01);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    s0_axi.awaddr = '0; s0_axi.awvalid = 0; s0_axi.wdata = '0; s0_axi.wstrb = '0;
    s0_axi.wvalid = 0; s0_axi.bready = 0; s0_axi.araddr = '0; s0_axi.arvalid = 0;
    s0_axi.rready = 0;

    #23;
    check("rst_ctl", {s0_axi.awready, s0_axi.wready, s0_axi.arready, s0_axi.bvalid, s0_axi.rvalid}, 5'b0);
    check("rst_resp", {s0_axi.bresp, s0_axi.rresp}, 4'b0);
    check("rst_rdata", s0_axi.rdata, 32'h0);
    @(negedge gclk); grst_n = 1'b1;
    @(posedge gclk); #1;
    check("rst_rdy", {s0_axi.awready, s0_axi.wready, s0_axi.arready}, 3'b111);

    wr(8'h04, 32'h0000_0017, 4'hF, 0, 0, OK);
    rd(8'h04, 0, 32'h0000_0017, OK);

    wr(8'h10, 32'h1122_3344, 4'hF, 0, 0, OK);
    wr(8'h10, 32'hAABB_CCDD, 4'b0101, 3, 0, OK);
    rd(8'h10, 0, 32'h11BB_33DD, OK);
    wr(8'h10, 32'hFFFF_FFFF, 4'h0, 0, 0, OK);
    rd(8'h13, 0, 32'h11BB_33DD, OK);

    wr(8'h20, 32'hDEAD_BEEF, 4'hF, 0, 0, SLV);
    rd(8'h24, 0, 32'h0, SLV);
    rd(8'h1C, 0, 32'h0, OK);
    rd(8'h04, 0, 32'h0000_0017, OK);
`ifdef AXIL_REGFILE_ID_EN
    rd(8'h00, 0, 32'hA5A5_0001, OK);
`else
    rd(8'h00, 0, 32'h0, OK);
`endif

    wr(8'h0C, 32'h0000_005A, 4'hF, 0, 5, OK);
    rd(8'h0C, 4, 32'h0000_005A, OK);

    // Read sampled at the same edge the write commits must see the old value.
    wr(8'h08, 32'h0000_001E, 4'hF, 0, 0, OK);
    check("sim_rdy", {s0_axi.awready, s0_axi.wready, s0_axi.arready}, 3'b111);
    s0_axi.awaddr = 8'h08; s0_axi.wdata = 32'h25; s0_axi.wstrb = 4'hF; s0_axi.araddr = 8'h08;
    s0_axi.awvalid = 1; s0_axi.wvalid = 1; s0_axi.arvalid = 1;
    @(posedge gclk); #1;
    s0_axi.awvalid = 0; s0_axi.wvalid = 0; s0_axi.arvalid = 0;
    check("sim_vld", {s0_axi.bvalid, s0_axi.rvalid}, 2'b11);
    check("sim_old", s0_axi.rdata, 32'h0000_001E);
    s0_axi.bready = 1; s0_axi.rready = 1;
    @(posedge gclk); #1;
    s0_axi.bready = 0; s0_axi.rready = 0;
    check("sim_done", {s0_axi.bvalid, s0_axi.rvalid}, 2'b00);
    rd(8'h08, 0, 32'h0000_0025, OK);

`ifdef AXIL_REGFILE_ID_EN
    rd(8'h00, 0, 32'hA5A5_0001, OK);
    wr(8'h00, 32'h0000_0005, 4'hF, 0, 0, SLV);
    rd(8'h00, 0, 32'hA5A5_0001, OK);
`else
    wr(8'h00, 32'h0000_0005, 4'hF, 0, 0, OK);
    rd(8'h00, 0, 32'h0000_0005, OK);
`endif

    // Reset with a write response and a read response both pending.
    s0_axi.awaddr = 8'h04; s0_axi.wdata = 32'h99; s0_axi.wstrb = 4'hF; s0_axi.araddr = 8'h04;
    s0_axi.awvalid = 1; s0_axi.wvalid = 1; s0_axi.arvalid = 1;
    @(posedge gclk); #1;
    s0_axi.awvalid = 0; s0_axi.wvalid = 0; s0_axi.arvalid = 0;
    check("mid_pend", {s0_axi.bvalid, s0_axi.rvalid}, 2'b11);
    #1 grst_n = 1'b0;
    #1;
    check("mid_rst_ctl", {s0_axi.awready, s0_axi.wready, s0_axi.arready, s0_axi.bvalid, s0_axi.rvalid}, 5'b0);
    check("mid_rst_data", s0_axi.rdata, 32'h0);
    @(negedge gclk); grst_n = 1'b1;
    @(posedge gclk); #1;
    rd(8'h04, 0, 32'h0, OK);
    rd(8'h08, 0, 32'h0, OK);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
